// File: rtl/fpdiv_seq.sv
// Sequential IEEE-754 single-precision divider, P = A / B.
// Restoring division at one quotient bit per clock, then guard-bit rounding and a registered load.
module fpdiv_seq (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] P,
  output logic        OF,
  output logic        UF,
  output logic        NaNF,
  output logic        InfF,
  output logic        DNF,
  output logic        ZF,
  output logic        DZF
);

  localparam int unsigned QBITS = 25;
  localparam int unsigned EXPW  = 10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] ALIGN  = 3'd2;
  localparam logic [2:0] DIV    = 3'd3;
  localparam logic [2:0] ROUND  = 3'd4;
  localparam logic [2:0] FINAL  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // Flag vector layout: {OF, UF, NaNF, InfF, DNF, ZF, DZF}
  localparam logic [6:0] FL_OF  = 7'b1000000;
  localparam logic [6:0] FL_UF  = 7'b0100000;
  localparam logic [6:0] FL_NAN = 7'b0010000;
  localparam logic [6:0] FL_INF = 7'b0001000;
  localparam logic [6:0] FL_DN  = 7'b0000100;
  localparam logic [6:0] FL_Z   = 7'b0000010;
  localparam logic [6:0] FL_DZ  = 7'b0000001;

  logic [2:0]             state_q, state_d;
  logic [31:0]            a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [EXPW-1:0] exp_q, exp_d;
  logic [23:0]            ma_q, ma_d, mb_q, mb_d;
  logic [25:0]            rem_q, rem_d;
  logic [QBITS-1:0]       quo_q, quo_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [23:0]            man_q, man_d;
  logic                   special_q, special_d;
  logic [31:0]            sp_p_q, sp_p_d;
  logic [6:0]             sp_fl_q, sp_fl_d;
  logic [31:0]            p_q, p_d;
  logic [6:0]             fl_q, fl_d;

  // Operand classification; denormals count as zero
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_dn;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    fa     = a_q[22:0];
    fb     = b_q[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    any_dn = (a_zero && (fa != 23'd0)) || (b_zero && (fb != 23'd0));
  end

  logic [25:0] mb_ext, rem_sub;
  logic        rem_ge;
  logic [24:0] rnd_sum;

  always_comb begin
    mb_ext  = {2'b00, mb_q};
    rem_ge  = rem_q >= mb_ext;
    rem_sub = rem_ge ? (rem_q - mb_ext) : rem_q;
    rnd_sum = {1'b0, quo_q[QBITS-1:1]} + {24'd0, quo_q[0]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    man_d     = man_q;
    special_d = special_q;
    sp_p_d    = sp_p_q;
    sp_fl_d   = sp_fl_q;
    p_d       = p_q;
    fl_d      = fl_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        sign_d    = a_q[31] ^ b_q[31];
        special_d = 1'b1;
        sp_fl_d   = any_dn ? FL_DN : 7'd0;
        state_d   = FINAL;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          sp_p_d  = 32'h7FC0_0000;
          sp_fl_d = sp_fl_d | FL_NAN;
        end else if (a_inf || b_zero) begin
          sp_p_d  = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
          sp_fl_d = sp_fl_d | FL_INF | (a_inf ? 7'd0 : FL_DZ);
        end else if (a_zero || b_inf) begin
          sp_p_d  = {a_q[31] ^ b_q[31], 31'd0};
          sp_fl_d = sp_fl_d | FL_Z;
        end else begin
          special_d = 1'b0;
          ma_d      = {1'b1, fa};
          mb_d      = {1'b1, fb};
          exp_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          state_d   = ALIGN;
        end
      end

      ALIGN: begin
        if (ma_q < mb_q) begin
          rem_d = {1'b0, ma_q, 1'b0};
          exp_d = exp_q - 10'sd1;
        end else begin
          rem_d = {2'b00, ma_q};
        end
        quo_d   = '0;
        cnt_d   = 5'd0;
        state_d = DIV;
      end

      DIV: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[QBITS-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (rnd_sum[24]) begin
          man_d = 24'h80_0000;
          exp_d = exp_q + 10'sd1;
        end else begin
          man_d = rnd_sum[23:0];
        end
        state_d = FINAL;
      end

      FINAL: begin
        if (special_q) begin
          p_d  = sp_p_q;
          fl_d = sp_fl_q;
        end else if (exp_q >= 10'sd255) begin
          p_d  = {sign_q, 8'hFF, 23'd0};
          fl_d = FL_OF | FL_INF;
        end else if (exp_q <= 10'sd0) begin
          p_d  = {sign_q, 31'd0};
          fl_d = FL_UF | FL_Z;
        end else begin
          p_d  = {sign_q, exp_q[7:0], man_q[22:0]};
          fl_d = 7'd0;
        end
        state_d = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      man_q     <= '0;
      special_q <= 1'b0;
      sp_p_q    <= '0;
      sp_fl_q   <= '0;
      p_q       <= '0;
      fl_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      man_q     <= man_d;
      special_q <= special_d;
      sp_p_q    <= sp_p_d;
      sp_fl_q   <= sp_fl_d;
      p_q       <= p_d;
      fl_q      <= fl_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign P    = p_q;
  assign OF   = fl_q[6];
  assign UF   = fl_q[5];
  assign NaNF = fl_q[4];
  assign InfF = fl_q[3];
  assign DNF  = fl_q[2];
  assign ZF   = fl_q[1];
  assign DZF  = fl_q[0];

endmodule

// File: doc/fpdiv_seq.md
Name: fpdiv_seq

Overview:
Sequential IEEE-754 single-precision divider (P = A / B). It uses the same Start/Done operand interface and the same status-flag set as the team's sequential FP multiplier, and sits beside it as the divide unit of the FP datapath. The mantissa quotient is produced by restoring division at one bit per clock, followed by a single rounding step and a registered result and flag load.

Parameters:
QBITS, 25, quotient bits generated (24 mantissa bits including hidden bit, plus 1 guard bit); fixed, not user-tunable.
EXPW, 10, internal signed exponent width.

Ports:
Clk    in   1   clock, rising edge
Rst    in   1   asynchronous, active-high reset
Start  in   1   request; sampled only in IDLE
A      in   32  dividend, IEEE single
B      in   32  divisor, IEEE single
Busy   out  1   high in every state except IDLE
Done   out  1   one-cycle pulse; P and flags valid
P      out  32  result, registered
OF     out  1   overflow (result forced to Inf)
UF     out  1   underflow (result flushed to zero)
NaNF   out  1   result is NaN
InfF   out  1   result is Inf
DNF    out  1   a denormal input was flushed to zero
ZF     out  1   result is zero
DZF    out  1   divide by zero (finite nonzero / 0)

Behaviour:
- Reset: Rst is asynchronous, active-high; clock is Clk. Reset forces the FSM to IDLE and clears P, all flags, Busy and Done to 0. Reset mid-operation aborts the operation and leaves no partial result.
- FSM states: IDLE, UNPACK, ALIGN, DIV (25 iterations), ROUND, FINAL, DONE.
- IDLE:
  - With Start=1, A and B are latched and the FSM moves to UNPACK.
  - Start is ignored in every other state.
  - P and the flags hold their previous values until the FINAL state of the next operation.
- UNPACK:
  - Split each operand into sign, exponent and fraction. Result sign = sA ^ sB.
  - An operand with exponent 0 and nonzero fraction is treated as zero and sets the DNF intent.
  - Special cases, checked in this priority order. On a match, the FSM goes to FINAL:
    - NaN: A or B is NaN, or 0/0, or Inf/Inf -> P = 0x7FC00000 (sign 0), NaNF=1.
    - Inf: A is Inf with B finite, or A finite nonzero with B zero -> P = {s, 0x7F800000[30:0]}, InfF=1. DZF=1 only in the B-zero case.
    - Zero: A is zero with B nonzero, or A finite with B Inf -> P = {s, 31'b0}, ZF=1.
  - Otherwise: ma = {1, fA}, mb = {1, fB}, e = eA - eB + 127 (10-bit signed); go to ALIGN.
- ALIGN:
  - If ma < mb: remainder R = ma << 1 and e = e - 1.
  - Else: R = ma.
  - Clear quotient q; iteration counter = 0.
- DIV, one cycle per iteration, 25 iterations:
  - If R >= mb: R = R - mb and qbit = 1. Else qbit = 0.
  - Then R = R << 1 and q = {q[23:0], qbit}. R is 26 bits wide.
  - After iteration 25, q[24] = 1 is guaranteed.
- ROUND:
  - m = q[24:1] + q[0]. This is round-to-nearest with ties away from zero, using the guard bit only; there is no sticky bit.
  - If the add carries to 2^24: m = 0x800000 and e = e + 1.
- Range checks, performed in FINAL on the post-round e:
  - e >= 255 -> P = {s, 0x7F800000[30:0]}, OF=1, InfF=1.
  - e <= 0 -> P = {s, 31'b0}, UF=1, ZF=1.
  - Otherwise P = {s, e[7:0], m[22:0]}.
- FINAL: load P and all seven flags in one edge. Flags not asserted are cleared. DNF is still reported when a special or zero result follows.
- DONE: Done=1 for exactly one cycle, Busy=1; next state is IDLE.
- Latency, counting the Start-accept cycle as cycle 0:
  - Normal path: Done in cycle 30.
  - Special-case path: Done in cycle 3.
- Back-to-back operation: Start may be asserted in the IDLE cycle directly after DONE.

Test Plan:
- A=0x40C00000, B=0x40000000 (6/2), Start 1 cycle -> Done in cycle 30, P=0x40400000, all flags 0; Busy high for cycles 1-30.
- A=0x3F800000, B=0x40400000 (1/3) -> P=0x3EAAAAAB (guard rounds up). A=0xBF800000, B=0x3F800000 -> P=0xBF800000.
- A=0x3F800000, B=0x00000000 -> Done in cycle 3, P=0x7F800000, InfF=1, DZF=1. A=0x00000000, B=0x00000000 -> P=0x7FC00000, NaNF=1. A=0x7F800000, B=0x7F800000 -> NaNF=1.
- A=0x7F000000, B=0x3E800000 -> P=0x7F800000, OF=1, InfF=1. A=0x00800000, B=0x40000000 -> P=0x00000000, UF=1, ZF=1.
- A=0x00000001 (denormal), B=0x3F800000 -> P=0x00000000, ZF=1, DNF=1. A=0x3F800000, B=0x7F800000 -> P=0x00000000, ZF=1.
- Pulse Start again at cycle 10 of an operation -> ignored; the original result is unchanged. Assert Rst at cycle 15 -> P=0, flags=0, Busy=0 immediately. A new Start then completes normally.
